// File: rtl/sync_arbiter_if.sv
// AXI address/response handshake bundle between the sync arbiter and the board memory.
// The write/read data and strobe buses travel outside this bundle.
interface sync_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 8
);
    logic [AXI_ID_WIDTH-1:0]   awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic                      awvalid;
    logic                      awready;

    logic                      wvalid;
    logic                      wready;
    logic                      wlast;

    logic [AXI_ID_WIDTH-1:0]   bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    logic [AXI_ID_WIDTH-1:0]   arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic                      arvalid;
    logic                      arready;

    logic [AXI_ID_WIDTH-1:0]   rid;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wvalid, wlast,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wvalid, wlast,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/sync_arbiter.sv
// Round-robin arbiter that serialises per-bank cache sync requests into single AXI
// burst transfers (writeback = AXI write, fill = AXI read), one transfer at a time.
module sync_arbiter #(
    parameter int BANKS          = 16,
    parameter int CHWIDTH        = 6,
    parameter int BEATS          = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [BANKS-1:0]           req,
    input  logic [BANKS-1:0]           dir,
    input  logic [BANKS*CHWIDTH-1:0]   crow,
    output logic [BANKS-1:0]           gnt,
    output logic [BANKS-1:0]           done,
    output logic                       err,
    output logic                       busy,
    sync_arbiter_if.master             axi
);

    localparam int IDX_W      = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int CNT_W      = $clog2(BEATS) + 1;
    localparam int XFER_BYTES = BEATS * (AXI_DATA_WIDTH / 8);

    localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [7:0]                AXLEN     = 8'(BEATS - 1);
    localparam logic [IDX_W:0]            BANKS_W   = (IDX_W+1)'(BANKS);
    localparam logic [AXI_ADDR_WIDTH-1:0] XFER_SZ   = AXI_ADDR_WIDTH'(XFER_BYTES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [IDX_W-1:0]          r_ptr;
    logic [IDX_W-1:0]          r_idx;
    logic [BANKS-1:0]          r_gnt;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [CNT_W-1:0]          r_beat;
    logic                      r_err;

    // Rotated request view: candidate gi is bank (ptr + gi) mod BANKS.
    logic [IDX_W-1:0] w_cand_idx [BANKS];
    logic [BANKS-1:0] w_cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, r_ptr} + (IDX_W+1)'(gi);
            assign w_cand_idx[gi] = (w_sum >= BANKS_W) ? IDX_W'(w_sum - BANKS_W)
                                                       : w_sum[IDX_W-1:0];
            assign w_cand_hit[gi] = req[w_cand_idx[gi]];
        end
    endgenerate

    logic                      w_found;
    logic [IDX_W-1:0]          w_sel;
    logic [IDX_W-1:0]          w_ptr_next;
    logic [CHWIDTH-1:0]        w_sel_crow;
    logic [AXI_ADDR_WIDTH-1:0] w_sel_row;
    logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
    logic                      w_beat_last;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (w_cand_hit[i]) begin
                w_found = 1'b1;
                w_sel   = w_cand_idx[i];
            end
        end
    end

    assign w_ptr_next  = (w_sel == IDX_W'(BANKS - 1)) ? '0 : w_sel + 1'b1;
    assign w_sel_crow  = crow[w_sel*CHWIDTH +: CHWIDTH];
    // Truncating each operand to the address width first gives the same low bits as the full product.
    assign w_sel_row   = (AXI_ADDR_WIDTH'(w_sel) << CHWIDTH) + AXI_ADDR_WIDTH'(w_sel_crow);
    assign w_sel_addr  = w_sel_row * XFER_SZ;
    assign w_beat_last = (r_beat == LAST_BEAT);

    // State register and transfer context.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt  <= BANKS'(1) << w_sel;
                        r_idx  <= w_sel;
                        r_ptr  <= w_ptr_next;
                        r_addr <= w_sel_addr;
                        r_beat <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_W: begin
                    if (axi.wready) begin
                        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
                    end
                end
                S_B: begin
                    if (axi.bvalid && ((axi.bresp != 2'b00) ||
                                       (axi.bid != AXI_ID_WIDTH'(r_idx)))) begin
                        r_err <= 1'b1;
                    end
                end
                S_R: begin
                    if (axi.rvalid) begin
                        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
                        // rlast must coincide exactly with the final counted beat.
                        if ((axi.rresp != 2'b00) ||
                            (axi.rid != AXI_ID_WIDTH'(r_idx)) ||
                            (axi.rlast != w_beat_last)) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_gnt <= '0;
                    r_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_found)                     w_state_next = dir[w_sel] ? S_AW : S_AR;
            S_AW:   if (axi.awready)                 w_state_next = S_W;
            S_W:    if (axi.wready && w_beat_last)   w_state_next = S_B;
            S_B:    if (axi.bvalid)                  w_state_next = S_DONE;
            S_AR:   if (axi.arready)                 w_state_next = S_R;
            S_R:    if (axi.rvalid && w_beat_last)   w_state_next = S_DONE;
            S_DONE:                                  w_state_next = S_IDLE;
            default:                                 w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; address/id/len fields are only driven while their channel is valid.
    always_comb begin
        axi.awid    = '0;
        axi.awaddr  = '0;
        axi.awlen   = '0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;
        axi.arid    = '0;
        axi.araddr  = '0;
        axi.arlen   = '0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        done        = '0;
        err         = 1'b0;
        case (r_state)
            S_AW: begin
                axi.awvalid = 1'b1;
                axi.awaddr  = r_addr;
                axi.awlen   = AXLEN;
                axi.awid    = AXI_ID_WIDTH'(r_idx);
            end
            S_W: begin
                axi.wvalid = 1'b1;
                axi.wlast  = w_beat_last;
            end
            S_B:  axi.bready = 1'b1;
            S_AR: begin
                axi.arvalid = 1'b1;
                axi.araddr  = r_addr;
                axi.arlen   = AXLEN;
                axi.arid    = AXI_ID_WIDTH'(r_idx);
            end
            S_R:  axi.rready = 1'b1;
            S_DONE: begin
                done = r_gnt;
                err  = r_err;
            end
            default: ;
        endcase
    end

    assign gnt  = r_gnt;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_sync_arbiter.sv
// Directed bench for sync_arbiter: write/read bursts, error reporting, AW backpressure,
// round-robin ordering and asynchronous reset during a burst.
module tb_sync_arbiter;
    localparam int BANKS = 16;
    localparam int CHW   = 4;
    localparam int BEATS = 8;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int IW    = 8;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [BANKS-1:0]       req;
    logic [BANKS-1:0]       dir;
    logic [BANKS*CHW-1:0]   crow;
    logic [BANKS-1:0]       gnt;
    logic [BANKS-1:0]       done;
    logic                   err;
    logic                   busy;

    int checks   = 0;
    int failures = 0;
    int multi    = 0;

    sync_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) axi ();

    sync_arbiter #(
        .BANKS(BANKS), .CHWIDTH(CHW), .BEATS(BEATS),
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .dir(dir), .crow(crow),
        .gnt(gnt), .done(done), .err(err), .busy(busy), .axi(axi)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if ($countones(gnt) > 1) multi++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 60 && done == '0; c++) step();
    endtask

    initial begin
        reset_n = 1'b0; req = '0; dir = '0; crow = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rresp = 0; axi.rlast = 0; axi.rid = 0;
        repeat (3) step();
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_awvalid", 32'(axi.awvalid), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        reset_n = 1'b1;
        step();

        // Writeback bank 5, row 3, all ready
        axi.awready = 1; axi.wready = 1; axi.bvalid = 1; axi.bid = 8'd5; axi.bresp = 0;
        axi.arready = 1; axi.rvalid = 1; axi.rid = 8'd5;
        crow[5*CHW +: CHW] = 4'd3; dir[5] = 1'b1; req[5] = 1'b1;
        step();
        req[5] = 1'b0;
        $display("TXN write bank=5 crow=3");
        chk("wr_gnt", 32'(gnt), 32'h0020);
        chk("wr_awvalid", 32'(axi.awvalid), 32'h1);
        chk("wr_awaddr", 32'(axi.awaddr), 32'h0A60);
        chk("wr_awlen", 32'(axi.awlen), 32'd7);
        chk("wr_awid", 32'(axi.awid), 32'd5);
        step();
        for (int i = 0; i < BEATS; i++) begin
            chk("wr_wvalid", 32'(axi.wvalid), 32'h1);
            chk("wr_wlast", 32'(axi.wlast), 32'(i == BEATS - 1));
            chk("wr_awvalid_off", 32'(axi.awvalid), 32'h0);
            step();
        end
        chk("wr_bready", 32'(axi.bready), 32'h1);
        step();
        chk("wr_done", 32'(done), 32'h0020);
        chk("wr_err", 32'(err), 32'h0);
        step();
        chk("wr_idle_busy", 32'(busy), 32'h0);
        chk("wr_idle_gnt", 32'(gnt), 32'h0);

        // Fill bank 5 with an error response on beat 3
        dir[5] = 1'b0; req[5] = 1'b1;
        step();
        req[5] = 1'b0;
        $display("TXN read bank=5 rresp=2 on beat 3");
        chk("rd_arvalid", 32'(axi.arvalid), 32'h1);
        chk("rd_araddr", 32'(axi.araddr), 32'h0A60);
        chk("rd_arlen", 32'(axi.arlen), 32'd7);
        chk("rd_arid", 32'(axi.arid), 32'd5);
        step();
        for (int i = 0; i < BEATS; i++) begin
            chk("rd_rready", 32'(axi.rready), 32'h1);
            axi.rresp = (i == 3) ? 2'd2 : 2'd0;
            axi.rlast = (i == BEATS - 1);
            step();
        end
        chk("rd_done", 32'(done), 32'h0020);
        chk("rd_err", 32'(err), 32'h1);
        axi.rresp = 0; axi.rlast = 0;
        step();

        // AW backpressure for 10 cycles; crow change mid-transfer must be ignored
        axi.awready = 0; dir[5] = 1'b1; req[5] = 1'b1;
        step();
        req[5] = 1'b0; crow[5*CHW +: CHW] = 4'd9;
        $display("TXN write bank=5 awready stalled 10 cycles");
        for (int i = 0; i < 10; i++) begin
            chk("stall_awvalid", 32'(axi.awvalid), 32'h1);
            chk("stall_awaddr", 32'(axi.awaddr), 32'h0A60);
            chk("stall_wvalid", 32'(axi.wvalid), 32'h0);
            step();
        end
        axi.awready = 1;
        step();
        chk("stall_w_start", 32'(axi.wvalid), 32'h1);
        wait_done();
        chk("stall_done", 32'(done), 32'h0020);
        chk("stall_err", 32'(err), 32'h0);
        step();
        crow[5*CHW +: CHW] = 4'd3;

        // Read with rlast on beat 6 of 8
        dir[5] = 1'b0; req[5] = 1'b1;
        step();
        req[5] = 1'b0;
        $display("TXN read bank=5 early rlast");
        step();
        for (int i = 0; i < BEATS; i++) begin
            chk("early_rready", 32'(axi.rready), 32'h1);
            chk("early_no_done", 32'(done), 32'h0);
            axi.rlast = (i == 5);
            step();
        end
        chk("early_done", 32'(done), 32'h0020);
        chk("early_err", 32'(err), 32'h1);
        axi.rlast = 0;
        step();

        // Round robin among banks 2, 9, 14 held from reset
        reset_n = 1'b0;
        req = '0; req[2] = 1; req[9] = 1; req[14] = 1;
        dir = '0; dir[2] = 1; dir[9] = 1; dir[14] = 1;
        step(); step();
        chk("rr_reset_gnt", 32'(gnt), 32'h0);
        reset_n = 1'b1;
        multi = 0;
        for (int n = 0; n < 4; n++) begin
            logic [BANKS-1:0] exp_gnt;
            int exp_k;
            exp_k = (n == 0 || n == 3) ? 2 : (n == 1 ? 9 : 14);
            exp_gnt = BANKS'(1) << exp_k;
            axi.bid = 8'(exp_k);
            for (int c = 0; c < 30 && gnt == '0; c++) step();
            $display("TXN round-robin grant %0d expect bank=%0d", n, exp_k);
            chk("rr_gnt", 32'(gnt), 32'(exp_gnt));
            if (n == 3) req = '0;
            wait_done();
            chk("rr_done", 32'(done), 32'(exp_gnt));
            chk("rr_err", 32'(err), 32'h0);
            step();
        end
        chk("rr_onehot", 32'(multi), 32'h0);

        // Asynchronous reset during the 4th W beat, then fresh transfer to bank 0
        dir[3] = 1'b1; crow[3*CHW +: CHW] = 4'd2; req[3] = 1'b1; axi.bid = 8'd3;
        step();
        req[3] = 1'b0;
        $display("TXN write bank=3 aborted by reset");
        step(); step(); step(); step();
        chk("abort_w_beat4", 32'(axi.wvalid), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("abort_gnt", 32'(gnt), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_wvalid", 32'(axi.wvalid), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        dir[0] = 1'b1; crow[0 +: CHW] = 4'd1; req[0] = 1'b1; axi.bid = 8'd0;
        step();
        chk("abort_hold_busy", 32'(busy), 32'h0);
        chk("abort_hold_done", 32'(done), 32'h0);
        reset_n = 1'b1;
        step();
        req[0] = 1'b0;
        $display("TXN write bank=0 after reset");
        chk("post_gnt", 32'(gnt), 32'h0001);
        chk("post_awaddr", 32'(axi.awaddr), 32'h0020);
        step();
        for (int i = 0; i < BEATS; i++) begin
            chk("post_wvalid", 32'(axi.wvalid), 32'h1);
            chk("post_wlast", 32'(axi.wlast), 32'(i == BEATS - 1));
            step();
        end
        wait_done();
        chk("post_done", 32'(done), 32'h0001);
        chk("post_err", 32'(err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
